// File: rtl/pow_nonce_search_pkg.sv
// Shared encodings and widths for the proof-of-work nonce search block.
package pow_nonce_search_pkg;

    localparam int HDR_BYTES = 12;
    localparam int NONCE_W   = 32;
    localparam int DIGEST_W  = 16;
    localparam int MSG_W     = 128;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/pow_nonce_search.sv
// Walks the nonce space for one latched header/target through an external hash core,
// reporting the first nonce whose leading digest bits fall below the target.
module pow_nonce_search
    import pow_nonce_search_pkg::*;
#(
    parameter int          ARM_CYCLES  = 4,
    parameter logic [31:0] NONCE_LIMIT = 32'hFFFF_FFFF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [15:0]  target,
    input  logic [7:0]   block0,
    input  logic [7:0]   block1,
    input  logic [7:0]   block2,
    input  logic [7:0]   block3,
    input  logic [7:0]   block4,
    input  logic [7:0]   block5,
    input  logic [7:0]   block6,
    input  logic [7:0]   block7,
    input  logic [7:0]   block8,
    input  logic [7:0]   block9,
    input  logic [7:0]   block10,
    input  logic [7:0]   block11,
    output logic         finish,
    output logic         found,
    output logic [7:0]   nonce0,
    output logic [7:0]   nonce1,
    output logic [7:0]   nonce2,
    output logic [7:0]   nonce3,
    output logic         hash_req,
    output logic [127:0] hash_msg,
    input  logic         hash_ack,
    input  logic [15:0]  hash_digest,
    output logic [2:0]   o_dbg_state
);

    localparam logic [7:0] ARM_LAST = 8'(ARM_CYCLES - 1);

    // Handshake: hash_req rises on entry to WAIT and holds with hash_msg stable until
    // hash_ack is seen in WAIT; acks arriving in any other state are ignored.
    state_t                 r_state;
    logic [7:0]             r_arm_cnt;
    logic [HDR_BYTES*8-1:0] r_hdr;
    logic [DIGEST_W-1:0]    r_target;
    logic [NONCE_W-1:0]     r_nonce;
    logic [NONCE_W-1:0]     r_nonce_out;
    logic                   r_finish;
    logic                   r_found;
    logic                   r_hash_req;
    logic [MSG_W-1:0]       r_hash_msg;

    logic [HDR_BYTES*8-1:0] w_header;
    logic                   w_hit;

    assign w_header = {block0, block1, block2, block3, block4, block5,
                       block6, block7, block8, block9, block10, block11};
    assign w_hit    = hash_digest < r_target;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_arm_cnt   <= '0;
            r_hdr       <= '0;
            r_target    <= '0;
            r_nonce     <= '0;
            r_nonce_out <= '0;
            r_finish    <= 1'b0;
            r_found     <= 1'b0;
            r_hash_req  <= 1'b0;
            r_hash_msg  <= '0;
        end else if (!start) begin
            // Dropping start aborts or retires the job from any state.
            r_state     <= ST_IDLE;
            r_arm_cnt   <= '0;
            r_nonce_out <= '0;
            r_finish    <= 1'b0;
            r_found     <= 1'b0;
            r_hash_req  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_arm_cnt <= '0;
                    r_state   <= ST_ARM;
                end
                ST_ARM: begin
                    if (r_arm_cnt == ARM_LAST) begin
                        r_hdr    <= w_header;
                        r_target <= target;
                        r_nonce  <= '0;
                        r_state  <= ST_ISSUE;
                    end else begin
                        r_arm_cnt <= r_arm_cnt + 8'd1;
                    end
                end
                ST_ISSUE: begin
                    r_hash_msg <= {r_hdr, r_nonce};
                    r_hash_req <= 1'b1;
                    r_state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (hash_ack) begin
                        r_hash_req <= 1'b0;
                        if (w_hit) begin
                            r_finish    <= 1'b1;
                            r_found     <= 1'b1;
                            r_nonce_out <= r_nonce;
                            r_state     <= ST_DONE;
                        end else if (r_nonce == NONCE_LIMIT) begin
                            r_finish    <= 1'b1;
                            r_found     <= 1'b0;
                            r_nonce_out <= NONCE_LIMIT;
                            r_state     <= ST_DONE;
                        end else begin
                            r_nonce <= r_nonce + 32'd1;
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign finish      = r_finish;
    assign found       = r_found;
    assign nonce0      = r_nonce_out[7:0];
    assign nonce1      = r_nonce_out[15:8];
    assign nonce2      = r_nonce_out[23:16];
    assign nonce3      = r_nonce_out[31:24];
    assign hash_req    = r_hash_req;
    assign hash_msg    = r_hash_msg;
    assign o_dbg_state = r_state;

endmodule
